// File: rtl/jt34061_sched.sv
// rtl/jt34061_sched.sv - VRAM cycle scheduler: SRT, refresh and host access arbitration and strobe sequencing
// Optional JT34061_SCHED_PAGE_EN: consecutive same-row host accesses stay in page mode.
module jt34061_sched #(
  parameter int          T_CAS       = 2,
  parameter int          T_PRE       = 2,
  parameter logic [11:0] RFSH_PERIOD = 12'd250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        line_req,
  input  logic [15:0] line_addr,
  input  logic [2:0]  rfsh_burst,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_din,
  output logic [7:0]  host_dout,
  output logic        host_ack,
  output logic        srt_miss,
  output logic [7:0]  rfsh_row,
  output logic        busy,
  output logic        vram_ras_n,
  output logic        vram_cas_n,
  output logic        vram_we_n,
  output logic        vram_trg_n,
  output logic [7:0]  vram_a,
  output logic [7:0]  vram_dout,
  input  logic [7:0]  vram_din
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW   = 3'd1,
    COL   = 3'd2,
    RHOLD = 3'd3,
    PRE   = 3'd4,
    PGAP  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OWN_SRT  = 2'd0,
    OWN_RFSH = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam logic [2:0] CAS_LAST = 3'(T_CAS - 1);
  localparam logic [2:0] PRE_LAST = 3'(T_PRE - 1);

  state_t      state, state_nxt;
  owner_t      owner;
  logic [2:0]  tcnt;
  logic [7:0]  lat_row, lat_col, lat_din;
  logic        lat_we;
  logic        srt_pend;
  logic [15:0] srt_addr, srt_cur;
  logic [11:0] rfsh_timer;
  logic        rfsh_wrap;
  logic [3:0]  rfsh_pend;
  logic [4:0]  rfsh_sum;
  logic        srt_want, rfsh_want;
  logic        grant, grant_srt, grant_rfsh;
  logic        cas_last, pre_last, host_done;
`ifdef JT34061_SCHED_PAGE_EN
  logic        page_hit;
`endif

  // A line_req arriving on the arbitration clk counts as pending SRT already
  always_comb begin
    srt_want   = srt_pend | line_req;
    srt_cur    = line_req ? line_addr : srt_addr;
    rfsh_want  = rfsh_pend != 4'd0;
    grant      = cen && (state == IDLE) && (srt_want || rfsh_want || host_req);
    grant_srt  = grant && srt_want;
    grant_rfsh = grant && !srt_want && rfsh_want;
    cas_last   = tcnt == CAS_LAST;
    pre_last   = tcnt == PRE_LAST;
    host_done  = cen && (state == COL) && cas_last && (owner == OWN_HOST);
    rfsh_wrap  = rfsh_timer == (RFSH_PERIOD - 12'd1);
    rfsh_sum   = {1'b0, rfsh_pend}
               + (rfsh_wrap ? {2'b00, rfsh_burst} : 5'd0)
               - {4'd0, grant_rfsh};
  end

`ifdef JT34061_SCHED_PAGE_EN
  always_comb begin
    page_hit = host_req && (host_addr[15:8] == lat_row) && !srt_want && !rfsh_want;
  end
`endif

  always_comb begin
    state_nxt = state;
    if (cen) begin
      case (state)
        IDLE:  if (grant) state_nxt = ROW;
        ROW:   state_nxt = (owner == OWN_RFSH) ? RHOLD : COL;
        COL: begin
          if (cas_last) begin
`ifdef JT34061_SCHED_PAGE_EN
            state_nxt = (owner == OWN_HOST) ? PGAP : PRE;
`else
            state_nxt = PRE;
`endif
          end
        end
        RHOLD: if (cas_last) state_nxt = PRE;
        PRE:   if (pre_last) state_nxt = IDLE;
`ifdef JT34061_SCHED_PAGE_EN
        PGAP:  state_nxt = page_hit ? COL : PRE;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_HOST;
      tcnt       <= 3'd0;
      lat_row    <= 8'd0;
      lat_col    <= 8'd0;
      lat_din    <= 8'd0;
      lat_we     <= 1'b0;
      srt_pend   <= 1'b0;
      srt_addr   <= 16'd0;
      rfsh_timer <= 12'd0;
      rfsh_pend  <= 4'd0;
      rfsh_row   <= 8'd0;
      host_dout  <= 8'd0;
      host_ack   <= 1'b0;
      srt_miss   <= 1'b0;
    end else begin
      host_ack <= host_done;
      srt_miss <= line_req && srt_pend;
      if (line_req) srt_addr <= line_addr;
      if (grant_srt)     srt_pend <= 1'b0;
      else if (line_req) srt_pend <= 1'b1;

      if (cen) begin
        state      <= state_nxt;
        tcnt       <= (state_nxt != state) ? 3'd0 : tcnt + 3'd1;
        rfsh_timer <= rfsh_wrap ? 12'd0 : rfsh_timer + 12'd1;
        rfsh_pend  <= (rfsh_sum > 5'd15) ? 4'd15 : rfsh_sum[3:0];

        if (grant) begin
          if (grant_srt) begin
            owner   <= OWN_SRT;
            lat_row <= srt_cur[15:8];
            lat_col <= srt_cur[7:0];
            lat_we  <= 1'b0;
          end else if (grant_rfsh) begin
            owner   <= OWN_RFSH;
            lat_row <= rfsh_row;
            lat_we  <= 1'b0;
          end else begin
            owner   <= OWN_HOST;
            lat_row <= host_addr[15:8];
            lat_col <= host_addr[7:0];
            lat_we  <= host_we;
            lat_din <= host_din;
          end
        end

        if (host_done && !lat_we) host_dout <= vram_din;
        if ((state == RHOLD) && cas_last) rfsh_row <= rfsh_row + 8'd1;
`ifdef JT34061_SCHED_PAGE_EN
        // Same row: only the column side of the access is reloaded
        if ((state == PGAP) && page_hit) begin
          lat_col <= host_addr[7:0];
          lat_we  <= host_we;
          lat_din <= host_din;
        end
`endif
      end
    end
  end

  // Strobes decode straight from state so an async reset releases them at once
  always_comb begin
    busy       = state != IDLE;
    vram_ras_n = 1'b1;
    vram_cas_n = 1'b1;
    vram_we_n  = 1'b1;
    vram_trg_n = 1'b1;
    vram_a     = 8'd0;
    vram_dout  = 8'd0;
    case (state)
      ROW: begin
        vram_ras_n = 1'b0;
        vram_trg_n = owner != OWN_SRT;
        vram_a     = lat_row;
      end
      COL: begin
        vram_ras_n = 1'b0;
        vram_cas_n = 1'b0;
        vram_trg_n = owner != OWN_SRT;
        vram_a     = lat_col;
        if ((owner == OWN_HOST) && lat_we) begin
          vram_we_n = 1'b0;
          vram_dout = lat_din;
        end
      end
      RHOLD: begin
        vram_ras_n = 1'b0;
        vram_a     = lat_row;
      end
      PGAP: begin
        vram_ras_n = 1'b0;
        vram_a     = lat_col;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jt34061_sched.sv
// tb/tb_jt34061_sched.sv - directed self-checking bench for jt34061_sched
module tb_jt34061_sched;

`ifdef JT34061_SCHED_PAGE_EN
  localparam int   EXP_RAS_FALLS = 1;
  localparam int   EXP_WR_TAIL   = 3;
  localparam logic EXP_ACK_RAS   = 1'b0;
`else
  localparam int   EXP_RAS_FALLS = 2;
  localparam int   EXP_WR_TAIL   = 2;
  localparam logic EXP_ACK_RAS   = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        line_req = 1'b0;
  logic [15:0] line_addr = 16'd0;
  logic [2:0]  rfsh_burst = 3'd0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = 16'd0;
  logic [7:0]  host_din = 8'd0;
  logic [7:0]  vram_din = 8'd0;

  logic [7:0]  host_dout, rfsh_row, vram_a, vram_dout;
  logic        host_ack, srt_miss, busy, ras_n, cas_n, we_n, trg_n;

  logic [7:0]  rf_host_dout, rf_rfsh_row, rf_vram_a, rf_vram_dout;
  logic        rf_host_ack, rf_srt_miss, rf_busy, rf_ras_n, rf_cas_n, rf_we_n, rf_trg_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jt34061_sched u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .line_req(line_req), .line_addr(line_addr), .rfsh_burst(rfsh_burst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_dout(host_dout), .host_ack(host_ack), .srt_miss(srt_miss),
    .rfsh_row(rfsh_row), .busy(busy),
    .vram_ras_n(ras_n), .vram_cas_n(cas_n), .vram_we_n(we_n), .vram_trg_n(trg_n),
    .vram_a(vram_a), .vram_dout(vram_dout), .vram_din(vram_din)
  );

  jt34061_sched #(.T_CAS(1), .T_PRE(1), .RFSH_PERIOD(12'd10)) u_rf (
    .clk(clk), .rst_n(rf_rst_n), .cen(cen),
    .line_req(1'b0), .line_addr(16'h0000), .rfsh_burst(3'd3),
    .host_req(1'b0), .host_we(1'b0), .host_addr(16'h0000), .host_din(8'h00),
    .host_dout(rf_host_dout), .host_ack(rf_host_ack), .srt_miss(rf_srt_miss),
    .rfsh_row(rf_rfsh_row), .busy(rf_busy),
    .vram_ras_n(rf_ras_n), .vram_cas_n(rf_cas_n), .vram_we_n(rf_we_n), .vram_trg_n(rf_trg_n),
    .vram_a(rf_vram_a), .vram_dout(rf_vram_dout), .vram_din(8'h00)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {ras_n, cas_n, we_n, trg_n}
  function automatic logic [15:0] strb();
    return {12'd0, ras_n, cas_n, we_n, trg_n};
  endfunction

  task automatic wait_idle(input int bound, output int cnt);
    cnt = 0;
    while (busy && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int ras_falls, cas_falls, acks;
    logic prev_ras, prev_cas, we_seen, cas_seen;
    logic [7:0] last_cas_a;
    logic [10:0] ras_bits;

    repeat (3) @(negedge clk);
    chk("reset_strobes", strb(), 16'h000F);
    chk("reset_vram_a", 16'(vram_a), 16'h0000);
    chk("reset_busy", 16'(busy), 16'h0000);
    chk("reset_ack_miss", 16'({host_ack, srt_miss}), 16'h0000);
    chk("reset_rows_data", 16'({rfsh_row, host_dout}), 16'h0000);
    chk("reset_vram_dout", 16'(vram_dout), 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Host write 0x1234 <- 0xA5
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_din = 8'hA5;
    @(negedge clk);
    chk("wr_row_strobes", strb(), 16'h0007);
    chk("wr_row_addr", 16'(vram_a), 16'h0012);
    chk("wr_row_busy", 16'(busy), 16'h0001);
    @(negedge clk);
    chk("wr_col1_strobes", strb(), 16'h0001);
    chk("wr_col1_addr", 16'(vram_a), 16'h0034);
    chk("wr_col1_data", 16'(vram_dout), 16'h00A5);
    chk("wr_col1_noack", 16'(host_ack), 16'h0000);
    @(negedge clk);
    chk("wr_col2_strobes", strb(), 16'h0001);
    @(negedge clk);
    chk("wr_ack", 16'(host_ack), 16'h0001);
    chk("wr_ack_ras", 16'(ras_n), 16'(EXP_ACK_RAS));
    chk("wr_ack_cas_we_trg", 16'({cas_n, we_n, trg_n}), 16'h0007);
    host_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", 16'(host_ack), 16'h0000);
    wait_idle(10, cnt);
    chk("wr_busy_tail", 16'(cnt), 16'(EXP_WR_TAIL - 1));

    // Host read 0x0203, held off by cen=0 first
    cen = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0203; vram_din = 8'h5A;
    repeat (3) @(negedge clk);
    chk("cen_hold_busy", 16'(busy), 16'h0000);
    cen = 1'b1;
    we_seen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      we_seen = we_seen | ~we_n;
      if (i == 1) begin
        chk("rd_row_strobes", strb(), 16'h0007);
        chk("rd_row_addr", 16'(vram_a), 16'h0002);
      end
      if (i == 2) begin
        chk("rd_col_strobes", strb(), 16'h0003);
        chk("rd_col_addr", 16'(vram_a), 16'h0003);
      end
    end
    chk("rd_ack", 16'(host_ack), 16'h0001);
    chk("rd_data", 16'(host_dout), 16'h005A);
    host_req = 1'b0; vram_din = 8'h00;
    wait_idle(10, cnt);
    chk("rd_idle", 16'(busy), 16'h0000);
    chk("rd_data_held", 16'(host_dout), 16'h005A);
    chk("rd_no_we", 16'(we_seen), 16'h0000);

    // line_req together with host_req: SRT first, then host
    line_req = 1'b1; line_addr = 16'h7788;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0506; vram_din = 8'h66;
    @(negedge clk);
    line_req = 1'b0;
    chk("srt_row_strobes", strb(), 16'h0006);
    chk("srt_row_addr", 16'(vram_a), 16'h0077);
    @(negedge clk);
    chk("srt_col_strobes", strb(), 16'h0002);
    chk("srt_col_addr", 16'(vram_a), 16'h0088);
    repeat (2) @(negedge clk);
    chk("srt_pre_strobes", strb(), 16'h000F);
    chk("srt_pre_noack", 16'(host_ack), 16'h0000);
    repeat (2) @(negedge clk);
    chk("srt_done_idle", 16'(busy), 16'h0000);
    @(negedge clk);
    chk("host_after_srt_strobes", strb(), 16'h0007);
    chk("host_after_srt_addr", 16'(vram_a), 16'h0005);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    chk("first_pend_nomiss", 16'(srt_miss), 16'h0000);
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    chk("srt_miss_pulse", 16'(srt_miss), 16'h0001);
    chk("host2_ack", 16'(host_ack), 16'h0001);
    chk("host2_data", 16'(host_dout), 16'h0066);
    host_req = 1'b0;
    @(negedge clk);
    chk("srt_miss_one_clk", 16'(srt_miss), 16'h0000);
    wait_idle(10, cnt);
    @(negedge clk);
    chk("pending_srt_strobes", strb(), 16'h0006);
    chk("pending_srt_addr", 16'(vram_a), 16'h0077);
    wait_idle(10, cnt);

    // Two reads in row 0x40
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h4001; vram_din = 8'h5A;
    ras_falls = 0; cas_falls = 0; acks = 0; prev_ras = 1'b1; prev_cas = 1'b1; last_cas_a = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (prev_ras && !ras_n) ras_falls++;
      if (prev_cas && !cas_n) begin
        cas_falls++;
        last_cas_a = vram_a;
      end
      prev_ras = ras_n; prev_cas = cas_n;
      if (host_ack) begin
        acks++;
        if (acks == 1) host_addr = 16'h4002;
        else host_req = 1'b0;
      end
    end
    chk("page_ras_falls", 16'(ras_falls), 16'(EXP_RAS_FALLS));
    chk("page_cas_falls", 16'(cas_falls), 16'h0002);
    chk("page_acks", 16'(acks), 16'h0002);
    chk("page_second_col", 16'(last_cas_a), 16'h0002);
    chk("page_idle", 16'(busy), 16'h0000);

    // Reset during COL of a write
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h5678; host_din = 8'h3C;
    repeat (2) @(negedge clk);
    chk("rst_pre_we", 16'(we_n), 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_strobes", strb(), 16'h000F);
    chk("rst_async_busy", 16'(busy), 16'h0000);
    host_req = 1'b0;
    @(negedge clk);
    chk("rst_no_ack", 16'(host_ack), 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_busy", 16'(busy), 16'h0000);
    chk("rst_release_ack", 16'(host_ack), 16'h0000);

    // Refresh: period 10, burst 3, T_CAS = T_PRE = 1
    @(negedge clk);
    rf_rst_n = 1'b1;
    cnt = 0;
    while (rf_ras_n && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    chk("rfsh_first_latency", 16'(cnt), 16'd11);
    ras_bits = '0;
    cas_seen = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      ras_bits[i] = rf_ras_n;
      cas_seen = cas_seen | ~rf_cas_n;
      if (i == 0) chk("rfsh_row0_addr", 16'(rf_vram_a), 16'h0000);
      if (i == 1) chk("rfsh_hold_addr", 16'(rf_vram_a), 16'h0000);
      if (i == 4) chk("rfsh_row1_addr", 16'(rf_vram_a), 16'h0001);
      if (i == 8) chk("rfsh_row2_addr", 16'(rf_vram_a), 16'h0002);
    end
    chk("rfsh_ras_pattern", 16'(ras_bits), 16'h04CC);
    chk("rfsh_no_cas", 16'(cas_seen), 16'h0000);
    chk("rfsh_row_after_burst", 16'(rf_rfsh_row), 16'h0003);
    cnt = 0;
    while (rf_rfsh_row != 8'hFF && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    chk("rfsh_reach_255", 16'(rf_rfsh_row), 16'h00FF);
    cnt = 0;
    while (rf_rfsh_row == 8'hFF && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("rfsh_wrap_0", 16'(rf_rfsh_row), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
